// File: rtl/song_player_pkg.sv
// Shared definitions for the song playback path: record layout, key codes, FSM states.
package song_player_pkg;

  localparam int KEY_MSB   = 27;
  localparam int KEY_LSB   = 26;
  localparam int START_MSB = 25;
  localparam int START_LSB = 13;
  localparam int DUR_MSB   = 12;
  localparam int DUR_LSB   = 0;

  localparam logic [1:0] KEY_NONE = 2'b00;
  localparam logic [1:0] KEY_DO   = 2'b01;
  localparam logic [1:0] KEY_RE   = 2'b10;
  localparam logic [1:0] KEY_MI   = 2'b11;

  localparam int          TICK_DIV_DEF = 500000;
  localparam logic [12:0] TIME_MAX     = 13'h1FFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_WAIT_START,
    S_PLAYING,
    S_DONE
  } state_t;

endpackage

// File: rtl/song_player_tone_gen.sv
// Square-wave generator: toggles every half-period of the selected key.
module tone_gen
  import song_player_pkg::*;
#(
  parameter int HALF_DO = 95556,
  parameter int HALF_RE = 85131,
  parameter int HALF_MI = 75843
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] key,
  input  logic       enable,
  output logic       tone_out
);

  localparam int HMAX  = (HALF_DO > HALF_RE) ? ((HALF_DO > HALF_MI) ? HALF_DO : HALF_MI)
                                             : ((HALF_RE > HALF_MI) ? HALF_RE : HALF_MI);
  localparam int CNT_W = $clog2(HMAX + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half_m1;
  logic [1:0]       key_q;

  always_comb begin
    half_m1 = '0;
    case (key)
      KEY_DO:  half_m1 = CNT_W'(HALF_DO - 1);
      KEY_RE:  half_m1 = CNT_W'(HALF_RE - 1);
      KEY_MI:  half_m1 = CNT_W'(HALF_MI - 1);
      default: half_m1 = '0;
    endcase
  end

  // A new key always starts from a clean low phase.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      tone_out <= 1'b0;
      key_q    <= KEY_NONE;
    end else if (!enable || key != key_q) begin
      cnt      <= '0;
      tone_out <= 1'b0;
      key_q    <= key;
    end else if (cnt == half_m1) begin
      cnt      <= '0;
      tone_out <= ~tone_out;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/song_player.sv
// Song playback: walks the song RAM and re-times each record against a 0.01 s tick.
module song_player
  import song_player_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int ADDR_W   = 7,
  parameter int HALF_DO  = 95556,
  parameter int HALF_RE  = 85131,
  parameter int HALF_MI  = 75843
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              play,
  input  logic              stop,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [27:0]       rd_data,
  output logic [1:0]        note_key,
  output logic              note_active,
  output logic              tone_out,
  output logic [12:0]       play_time,
  output logic              busy,
  output logic              done
);

  localparam int                DIV_W    = $clog2(TICK_DIV + 1);
  localparam logic [DIV_W-1:0]  DIV_LOAD = DIV_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick, restart;
  logic [12:0]       pt_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [1:0]        key_nxt;
  logic              act_nxt;
  logic [12:0]       dur_cnt, dur_nxt;
  logic [1:0]        rec_key, rec_key_nxt;
  logic [12:0]       rec_start, rec_start_nxt;
  logic [12:0]       rec_dur, rec_dur_nxt;

  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);
  assign tick   = busy && (div_cnt == '0);
  assign pt_nxt = (tick && play_time != TIME_MAX) ? play_time + 13'd1 : play_time;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    addr_nxt      = rd_addr;
    key_nxt       = note_key;
    act_nxt       = note_active;
    dur_nxt       = dur_cnt;
    rec_key_nxt   = rec_key;
    rec_start_nxt = rec_start;
    rec_dur_nxt   = rec_dur;
    restart       = 1'b0;
    if (stop) begin
      state_nxt = S_IDLE;
      key_nxt   = KEY_NONE;
      act_nxt   = 1'b0;
    end else if (play) begin
      state_nxt = S_FETCH;
      addr_nxt  = '0;
      key_nxt   = KEY_NONE;
      act_nxt   = 1'b0;
      restart   = 1'b1;
    end else begin
      case (state)
        S_FETCH: state_nxt = S_LATCH;
        S_LATCH: begin
          rec_key_nxt   = rd_data[KEY_MSB:KEY_LSB];
          rec_start_nxt = rd_data[START_MSB:START_LSB];
          rec_dur_nxt   = rd_data[DUR_MSB:DUR_LSB];
          if (rd_data[KEY_MSB:KEY_LSB] == KEY_NONE) begin
            state_nxt = S_DONE;
          end else if (rd_data[DUR_MSB:DUR_LSB] == 13'd0) begin
            addr_nxt  = rd_addr + 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WAIT_START;
          end
        end
        S_WAIT_START: begin
          // Compare against the post-edge time so an on-time note starts with its tick.
          if (play_time == TIME_MAX) begin
            state_nxt = S_DONE;
          end else if (pt_nxt >= rec_start) begin
            dur_nxt   = rec_dur;
            key_nxt   = rec_key;
            act_nxt   = 1'b1;
            state_nxt = S_PLAYING;
          end
        end
        S_PLAYING: begin
          if (tick) begin
            if (dur_cnt <= 13'd1) begin
              dur_nxt = '0;
              key_nxt = KEY_NONE;
              act_nxt = 1'b0;
              if (rd_addr == ADDR_MAX) begin
                state_nxt = S_DONE;
              end else begin
                addr_nxt  = rd_addr + 1'b1;
                state_nxt = S_FETCH;
              end
            end else begin
              dur_nxt = dur_cnt - 13'd1;
            end
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr     <= '0;
      note_key    <= KEY_NONE;
      note_active <= 1'b0;
      dur_cnt     <= '0;
      rec_key     <= KEY_NONE;
      rec_start   <= '0;
      rec_dur     <= '0;
    end else begin
      rd_addr     <= addr_nxt;
      note_key    <= key_nxt;
      note_active <= act_nxt;
      dur_cnt     <= dur_nxt;
      rec_key     <= rec_key_nxt;
      rec_start   <= rec_start_nxt;
      rec_dur     <= rec_dur_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt   <= DIV_LOAD;
      play_time <= '0;
    end else if (restart) begin
      div_cnt   <= DIV_LOAD;
      play_time <= '0;
    end else if (busy) begin
      div_cnt   <= tick ? DIV_LOAD : div_cnt - 1'b1;
      play_time <= pt_nxt;
    end
  end

  tone_gen #(
    .HALF_DO(HALF_DO),
    .HALF_RE(HALF_RE),
    .HALF_MI(HALF_MI)
  ) u_tone (
    .clock   (clock),
    .reset_n (reset_n),
    .key     (note_key),
    .enable  (note_active),
    .tone_out(tone_out)
  );

endmodule

// File: tb/tb_song_player.sv
// Bench for song_player: RAM model, per-note tick-interval reference, scenario tasks.
module tb_song_player;
  import song_player_pkg::*;

  localparam int TD = 4;
  localparam int AW = 7;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          play = 1'b0;
  logic          stop = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [27:0]   rd_data = '0;
  logic [1:0]    note_key;
  logic          note_active, tone_out, busy, done;
  logic [12:0]   play_time;

  logic [27:0] ram [128];
  int total = 0;
  int bad   = 0;

  int          tr_pt[$], tr_addr[$];
  logic [1:0]  tr_key[$];
  logic        tr_act[$], tr_done[$], tr_busy[$];
  int          m_key[$], m_s[$], m_e[$], m_prev[$];
  int          m_last_addr;

  song_player #(.TICK_DIV(TD), .ADDR_W(AW), .HALF_DO(3), .HALF_RE(4), .HALF_MI(5)) dut (
    .clock(clock), .reset_n(reset_n), .play(play), .stop(stop),
    .rd_addr(rd_addr), .rd_data(rd_data), .note_key(note_key), .note_active(note_active),
    .tone_out(tone_out), .play_time(play_time), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) rd_data <= ram[rd_addr];

  function automatic logic [27:0] rec(input int k, input int s, input int d);
    logic [1:0]  kk = k[1:0];
    logic [12:0] ss = s[12:0];
    logic [12:0] dd = d[12:0];
    return {kk, ss, dd};
  endfunction

  task automatic clear_ram();
    foreach (ram[i]) ram[i] = '0;
  endtask

  // Reference: each note sounds for [max(start, previous end), +duration) in ticks.
  task automatic build_model();
    int prev = 0;
    m_key.delete(); m_s.delete(); m_e.delete(); m_prev.delete();
    m_last_addr = 127;
    for (int a = 0; a < 128; a++) begin
      int k  = int'(ram[a][27:26]);
      int st = int'(ram[a][25:13]);
      int d  = int'(ram[a][12:0]);
      int s;
      if (k == 0) begin m_last_addr = a; break; end
      if (d == 0) continue;
      s = (st > prev) ? st : prev;
      m_key.push_back(k); m_s.push_back(s); m_e.push_back(s + d); m_prev.push_back(prev);
      prev = s + d;
    end
  endtask

  function automatic int exp_key(input int pt);
    foreach (m_s[i]) if (m_s[i] <= pt && pt < m_e[i]) return m_key[i];
    return 0;
  endfunction

  // A note fetched right as the previous one ends sounds a few cycles into its first tick.
  function automatic bit gap_ok(input int pt);
    foreach (m_s[i]) if (m_s[i] == pt && m_s[i] == m_prev[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int first_pt(input int k);
    foreach (tr_key[i]) if (int'(tr_key[i]) == k) return tr_pt[i];
    return -1;
  endfunction

  function automatic int last_pt(input int k);
    for (int i = tr_key.size() - 1; i >= 0; i--) if (int'(tr_key[i]) == k) return tr_pt[i];
    return -1;
  endfunction

  function automatic int done_cnt();
    int n = 0;
    foreach (tr_done[i]) if (tr_done[i]) n++;
    return n;
  endfunction

  task automatic pulse_play();
    @(negedge clock); play = 1'b1;
    @(negedge clock); play = 1'b0;
  endtask

  task automatic run_song(input int budget);
    tr_pt.delete(); tr_addr.delete(); tr_key.delete();
    tr_act.delete(); tr_done.delete(); tr_busy.delete();
    pulse_play();
    for (int c = 0; ; c++) begin
      tr_pt.push_back(int'(play_time)); tr_addr.push_back(int'(rd_addr));
      tr_key.push_back(note_key); tr_act.push_back(note_active);
      tr_done.push_back(done); tr_busy.push_back(busy);
      if (!busy) break;
      if (c >= budget) begin
        total++; bad++;
        $display("FAIL song_timeout: still busy after %0d cycles, required idle", budget);
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic wait_pt(input int pt, input string name);
    for (int c = 0; c < 200 && int'(play_time) != pt; c++) @(negedge clock);
    total++;
    if (int'(play_time) !== pt) begin
      bad++; $display("FAIL %s: play_time=%0d, required %0d", name, play_time, pt);
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    total++;
    if ({note_key, note_active, tone_out, busy, done} !== 6'b0) begin
      bad++; $display("FAIL reset_flags: key=%0d act=%0b tone=%0b busy=%0b done=%0b, required 0",
                      note_key, note_active, tone_out, busy, done);
    end
    total++;
    if (play_time !== 13'd0 || rd_addr !== '0) begin
      bad++; $display("FAIL reset_regs: play_time=%0d rd_addr=%0d, required 0", play_time, rd_addr);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single_note();
    int n;
    clear_ram();
    ram[0] = rec(1, 5, 3);
    run_song(300);
    n = tr_busy.size();
    total++;
    if (first_pt(1) !== 5) begin bad++; $display("FAIL single_on: first pt=%0d, required 5", first_pt(1)); end
    total++;
    if (last_pt(1) !== 7) begin bad++; $display("FAIL single_off: last pt=%0d, required 7", last_pt(1)); end
    total++;
    if (done_cnt() !== 1) begin bad++; $display("FAIL single_done: pulses=%0d, required 1", done_cnt()); end
    total++;
    if (!(n >= 2 && tr_done[n-2] === 1'b1 && tr_busy[n-1] === 1'b0)) begin
      bad++; $display("FAIL single_busy_fall: busy not low the cycle after done (n=%0d), required yes", n);
    end
  endtask

  task automatic test_late_start();
    clear_ram();
    ram[0] = rec(2, 2, 4);
    ram[1] = rec(3, 3, 2);
    run_song(300);
    total++;
    if (first_pt(2) !== 2 || last_pt(2) !== 5) begin
      bad++; $display("FAIL late_first: key2 pt %0d..%0d, required 2..5", first_pt(2), last_pt(2));
    end
    total++;
    if (first_pt(3) !== 6 || last_pt(3) !== 7) begin
      bad++; $display("FAIL late_second: key3 pt %0d..%0d, required 6..7", first_pt(3), last_pt(3));
    end
    total++;
    if (done_cnt() !== 1) begin bad++; $display("FAIL late_done: pulses=%0d, required 1", done_cnt()); end
  endtask

  task automatic test_zero_dur();
    int stray = 0;
    clear_ram();
    ram[0] = rec(1, 1, 0);
    ram[1] = rec(3, 2, 1);
    run_song(300);
    foreach (tr_act[i]) if (tr_act[i] && tr_key[i] != 2'd3) stray++;
    total++;
    if (first_pt(1) !== -1 || stray !== 0) begin
      bad++; $display("FAIL zero_skip: key1 pt=%0d stray=%0d, required -1 and 0", first_pt(1), stray);
    end
    total++;
    if (first_pt(3) !== 2 || last_pt(3) !== 2) begin
      bad++; $display("FAIL zero_next: key3 pt %0d..%0d, required 2..2", first_pt(3), last_pt(3));
    end
  endtask

  task automatic test_stop();
    int saw_done = 0;
    clear_ram();
    ram[0] = rec(1, 5, 3);
    pulse_play();
    wait_pt(6, "stop_wait");
    total++;
    if (note_active !== 1'b1) begin bad++; $display("FAIL stop_pre: note_active=%0b, required 1", note_active); end
    stop = 1'b1;
    @(negedge clock); stop = 1'b0;
    total++;
    if (note_active !== 1'b0 || busy !== 1'b0 || note_key !== 2'd0) begin
      bad++; $display("FAIL stop_clear: act=%0b busy=%0b key=%0d, required 0", note_active, busy, note_key);
    end
    for (int c = 0; c < 10; c++) begin
      if (done) saw_done++;
      @(negedge clock);
    end
    total++;
    if (saw_done !== 0) begin bad++; $display("FAIL stop_done: done cycles=%0d, required 0", saw_done); end
    pulse_play();
    wait_pt(6, "restart_wait");
    play = 1'b1;
    @(negedge clock); play = 1'b0;
    total++;
    if (note_active !== 1'b0 || busy !== 1'b1 || play_time !== 13'd0 || rd_addr !== '0) begin
      bad++; $display("FAIL restart: act=%0b busy=%0b pt=%0d addr=%0d, required 0 1 0 0",
                      note_active, busy, play_time, rd_addr);
    end
    stop = 1'b1;
    @(negedge clock); stop = 1'b0;
    play = 1'b1; stop = 1'b1;
    @(negedge clock); play = 1'b0; stop = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL play_stop_idle: busy=%0b, required 0", busy); end
  endtask

  task automatic test_full_song();
    int seen = 0, wrap = 0, notes = 0;
    logic [1:0] pk = 2'd0;
    for (int a = 0; a < 128; a++) ram[a] = rec(1 + a % 3, a, 1);
    run_song(3000);
    foreach (tr_addr[i]) begin
      if (tr_addr[i] == 127) seen = 1;
      else if (seen) wrap = 1;
    end
    foreach (tr_key[i]) begin
      if (tr_key[i] != 2'd0 && pk == 2'd0) notes++;
      pk = tr_key[i];
    end
    total++;
    if (notes !== 128) begin bad++; $display("FAIL full_notes: notes=%0d, required 128", notes); end
    total++;
    if (wrap !== 0 || tr_addr[tr_addr.size()-1] !== 127) begin
      bad++; $display("FAIL full_nowrap: wrap=%0d final addr=%0d, required 0 and 127",
                      wrap, tr_addr[tr_addr.size()-1]);
    end
    total++;
    if (done_cnt() !== 1 || last_pt(2) !== 127) begin
      bad++; $display("FAIL full_end: done=%0d last pt=%0d, required 1 and 127", done_cnt(), last_pt(2));
    end
  endtask

  task automatic test_tone_and_reset();
    for (int k = 1; k <= 3; k++) begin
      int nchg = 0, last = -1, badint = 0;
      logic pv;
      clear_ram();
      ram[0] = rec(k, 0, 20);
      pulse_play();
      for (int c = 0; c < 20 && !note_active; c++) @(negedge clock);
      pv = tone_out;
      for (int c = 0; c < 40; c++) begin
        @(negedge clock);
        if (tone_out !== pv) begin
          if (last >= 0 && c - last != k + 2) badint++;
          last = c; nchg++;
        end
        pv = tone_out;
      end
      total++;
      if (nchg < 5 || badint !== 0) begin
        bad++; $display("FAIL tone_key%0d: toggles=%0d bad intervals=%0d, required >=5 and 0", k, nchg, badint);
      end
    end
    for (int c = 0; c < 10 && tone_out !== 1'b1; c++) @(negedge clock);
    total++;
    if (note_active !== 1'b1 || tone_out !== 1'b1) begin
      bad++; $display("FAIL reset_pre: act=%0b tone=%0b, required 1 1", note_active, tone_out);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (note_key !== 2'd0 || note_active !== 1'b0 || tone_out !== 1'b0 || play_time !== 13'd0) begin
      bad++; $display("FAIL reset_mid_note: key=%0d act=%0b tone=%0b pt=%0d, required 0",
                      note_key, note_active, tone_out, play_time);
    end
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int n, errs = 0, bad_pt = -1;
      clear_ram();
      n = $urandom_range(1, 5);
      for (int a = 0; a < n; a++)
        ram[a] = rec($urandom_range(1, 3), $urandom_range(0, 20), $urandom_range(1, 4));
      build_model();
      run_song(1000);
      foreach (tr_pt[i]) begin
        if (tr_busy[i]) begin
          int e = exp_key(tr_pt[i]);
          bit key_bad = (int'(tr_key[i]) != e) && !(tr_key[i] == 2'd0 && gap_ok(tr_pt[i]));
          if (key_bad || tr_act[i] != (tr_key[i] != 2'd0)) begin
            if (errs == 0) bad_pt = tr_pt[i];
            errs++;
          end
        end
      end
      total++;
      if (errs !== 0) begin
        bad++; $display("FAIL rand%0d_keys: %0d wrong samples, first at pt=%0d, required 0", it, errs, bad_pt);
      end
      total++;
      if (done_cnt() !== 1 || tr_addr[tr_addr.size()-1] !== m_last_addr) begin
        bad++; $display("FAIL rand%0d_end: done=%0d addr=%0d, required 1 and %0d",
                        it, done_cnt(), tr_addr[tr_addr.size()-1], m_last_addr);
      end
    end
  endtask

  initial begin
    clear_ram();
    test_reset();
    test_single_note();
    test_late_start();
    test_zero_dur();
    test_stop();
    test_full_song();
    test_tone_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
